chick_track_ctrl: RTL and testbench
===================================

Name: chick_track_ctrl

Overview:
Parametrised position controller for all players on the circular chicken track. It replaces the per-player fixed counters with one block that does several things: loads start tiles from the runtime player count, animates moves one tile per clock, skips occupied tiles, counts laps and declares a winner. It sits between the turn/card-match logic (which issues moves) and the display driver (which reads positions).

Parameters:
MAX_PLAYERS, 4, number of player channels implemented (2..8)
TRACK_LEN, 24, tiles on the circular track; positions 0..TRACK_LEN-1
POS_W, 5, position width, >= clog2(TRACK_LEN)
STEP_W, 3, width of requested step count
LAP_W, 2, lap counter width per player
WIN_LAPS, 2, laps needed to win (1..2^LAP_W-1)

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  reset; asynchronous, active-high
init  in  1  one-cycle pulse: start a new game
num_players  in  4  active players, sampled on init; legal 2..MAX_PLAYERS
move_valid  in  1  move request
move_ready  out  1  high when a request will be accepted
move_player  in  3  index of the player to move
move_steps  in  STEP_W  tiles to advance
pos  out  MAX_PLAYERS*POS_W  packed positions; player i at [i*POS_W +: POS_W]
laps  out  MAX_PLAYERS*LAP_W  packed lap counts
active  out  MAX_PLAYERS  bit i set when player i is in the game
move_done  out  1  one-cycle pulse when a move finishes
err  out  1  one-cycle pulse on a rejected init or move
winner_valid  out  1  held high once a player reaches WIN_LAPS
winner_id  out  3  index of the winner; valid when winner_valid is high

Behaviour:
- Reset (async): state=IDLE. All pos, laps and start tiles = 0. active=0, move_ready=0, move_done=0, err=0, winner_valid=0, winner_id=0.
- FSM states: IDLE, PLAY, STEP, SKIP, DONE, WON.
- IDLE:
  - init with legal num_players -> for each i<num_players: start_i = i*(TRACK_LEN/num_players) (integer division), pos_i=start_i, laps_i=0, active_i=1. All other channels: pos=0, active=0. Next state PLAY.
  - Illegal num_players -> err pulse, stay in IDLE.
- init in any state other than IDLE re-initialises the game the same way. This includes a move in progress; the move is aborted with no move_done. An illegal num_players in these states gives err only and leaves the game unchanged.
- move_ready = 1 only in PLAY. A handshake is move_valid & move_ready.
  - move_player >= num_players -> err pulse, stay in PLAY.
  - move_steps = 0 -> move_done pulse in the next cycle, nothing changes.
  - Otherwise latch the player and remaining=move_steps, then go to STEP.
- STEP: each cycle the mover advances one tile.
  - Wrap: TRACK_LEN-1 -> 0.
  - If the new tile equals start_mover, laps_mover increments (saturating at max).
  - remaining decrements. When it reaches 0: if the tile is occupied by another active player, go to SKIP; else go to DONE.
- SKIP: advance one tile per cycle, with the same wrap and lap rules, until the tile is unoccupied, then go to DONE. Termination is guaranteed because num_players < TRACK_LEN.
- DONE: move_done pulses for one cycle.
  - If laps_mover >= WIN_LAPS: winner_valid=1, winner_id=mover, go to WON.
  - Else go to PLAY.
- WON: moves ignored (move_ready=0); only init or rst exit this state.
- Latency: a move accepted at edge t updates pos at edges t+1 .. t+move_steps+skips. move_done is high in the cycle after the last update.
- Lap crossing inside a SKIP counts normally.
- Passing other players mid-move has no effect; only the landing tile is checked.
- Positions of non-moving players never change during a move.

Test Plan:
- Start tiles: rst, init num_players=4 -> pos = {18,12,6,0} (p3..p0), active=4'b1111. Then init num_players=3 -> {0,16,8,0}, active=4'b0111.
- Wrap and lap: N=2, move p1 (start 12) by 7 repeatedly until it crosses tile 12. The tile sequence must wrap 23->0, and laps1 must increment exactly on landing at 12. move_done arrives 8 cycles after acceptance for steps=7.
- Collision skip: N=4, p0 at 0, p1 at 6. Move p0 by 6 -> p0 lands on 7 after 7 update cycles, move_done follows. Also place p1 at 7: p0 lands on 8.
- Rejects: init num_players=1 and init num_players=9 -> err pulse, state unchanged. N=3, move_player=3 -> err pulse, no movement. move_valid while in STEP -> move_ready=0, request not taken.
- Win: WIN_LAPS=1, N=2, step p0 around the track -> winner_valid=1, winner_id=0 the cycle after the lap. Further moves are ignored; init clears winner_valid.
- Async reset mid-move: assert rst during STEP between clock edges -> all outputs zero immediately. After release, move_ready=0 until init.

Source files
------------

// File: rtl/chick_track_ctrl.sv
// Position controller for every player on the circular chicken track:
// start-tile loading, one-tile-per-clock moves, landing-collision skip, lap counting and winner latch.
module chick_track_ctrl #(
  parameter int MAX_PLAYERS = 4,
  parameter int TRACK_LEN   = 24,
  parameter int POS_W       = 5,
  parameter int STEP_W      = 3,
  parameter int LAP_W       = 2,
  parameter int WIN_LAPS    = 2
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         init_i,
  input  logic [3:0]                   num_players_i,
  input  logic                         move_valid_i,
  output logic                         move_ready_o,
  input  logic [2:0]                   move_player_i,
  input  logic [STEP_W-1:0]            move_steps_i,
  output logic [MAX_PLAYERS*POS_W-1:0] pos_o,
  output logic [MAX_PLAYERS*LAP_W-1:0] laps_o,
  output logic [MAX_PLAYERS-1:0]       active_o,
  output logic                         move_done_o,
  output logic                         err_o,
  output logic                         winner_valid_o,
  output logic [2:0]                   winner_id_o
);

  localparam int IDX_W = (MAX_PLAYERS > 1) ? $clog2(MAX_PLAYERS) : 1;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PLAY = 3'd1,
    S_STEP = 3'd2,
    S_SKIP = 3'd3,
    S_DONE = 3'd4,
    S_WON  = 3'd5
  } state_t;

  state_t            state_q;
  logic [POS_W-1:0]  pos_q   [MAX_PLAYERS];
  logic [POS_W-1:0]  start_q [MAX_PLAYERS];
  logic [LAP_W-1:0]  laps_q  [MAX_PLAYERS];
  logic [MAX_PLAYERS-1:0] active_q;
  logic [3:0]        nplayers_q;
  logic [IDX_W-1:0]  mover_q;
  logic [STEP_W-1:0] remaining_q;
  logic              move_ready_q;
  logic              move_done_q;
  logic              err_q;
  logic              winner_valid_q;
  logic [2:0]        winner_id_q;

  logic              init_ok_d;
  logic [POS_W-1:0]  spacing_d;
  logic [POS_W-1:0]  adv_pos_d;
  logic [LAP_W-1:0]  laps_adv_d;
  logic              occupied_d;
  logic              player_ok_d;

  // Tile spacing between start tiles, TRACK_LEN / n for each legal player count.
  function automatic logic [POS_W-1:0] tile_spacing(input logic [3:0] n);
    case (n)
      4'd2:    return POS_W'(TRACK_LEN / 2);
      4'd3:    return POS_W'(TRACK_LEN / 3);
      4'd4:    return POS_W'(TRACK_LEN / 4);
      4'd5:    return POS_W'(TRACK_LEN / 5);
      4'd6:    return POS_W'(TRACK_LEN / 6);
      4'd7:    return POS_W'(TRACK_LEN / 7);
      4'd8:    return POS_W'(TRACK_LEN / 8);
      default: return {POS_W{1'b0}};
    endcase
  endfunction

  // Next tile of the mover with wrap, its lap update, and landing occupancy by other players.
  always_comb begin
    init_ok_d   = init_i && (num_players_i >= 4'd2) && (num_players_i <= 4'(MAX_PLAYERS));
    spacing_d   = tile_spacing(num_players_i);
    player_ok_d = ({1'b0, move_player_i} < nplayers_q);
    adv_pos_d   = (pos_q[mover_q] == POS_W'(TRACK_LEN - 1)) ? {POS_W{1'b0}}
                                                             : pos_q[mover_q] + POS_W'(1);
    laps_adv_d  = laps_q[mover_q] + LAP_W'((adv_pos_d == start_q[mover_q]) &&
                                           (laps_q[mover_q] != {LAP_W{1'b1}}));
    occupied_d  = 1'b0;
    for (int i = 0; i < MAX_PLAYERS; i++) begin
      occupied_d = occupied_d | (active_q[i] && (IDX_W'(i) != mover_q) && (pos_q[i] == adv_pos_d));
    end
  end

  // Game FSM; init has priority in every state and aborts any move in flight.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q        <= S_IDLE;
      for (int i = 0; i < MAX_PLAYERS; i++) begin
        pos_q[i]   <= {POS_W{1'b0}};
        start_q[i] <= {POS_W{1'b0}};
        laps_q[i]  <= {LAP_W{1'b0}};
      end
      active_q       <= {MAX_PLAYERS{1'b0}};
      nplayers_q     <= 4'd0;
      mover_q        <= {IDX_W{1'b0}};
      remaining_q    <= {STEP_W{1'b0}};
      move_ready_q   <= 1'b0;
      move_done_q    <= 1'b0;
      err_q          <= 1'b0;
      winner_valid_q <= 1'b0;
      winner_id_q    <= 3'd0;
    end else begin
      move_done_q <= 1'b0;
      err_q       <= 1'b0;
      if (init_ok_d) begin
        for (int i = 0; i < MAX_PLAYERS; i++) begin
          if (4'(i) < num_players_i) begin
            pos_q[i]    <= POS_W'(i) * spacing_d;
            start_q[i]  <= POS_W'(i) * spacing_d;
            active_q[i] <= 1'b1;
          end else begin
            pos_q[i]    <= {POS_W{1'b0}};
            start_q[i]  <= {POS_W{1'b0}};
            active_q[i] <= 1'b0;
          end
          laps_q[i] <= {LAP_W{1'b0}};
        end
        nplayers_q     <= num_players_i;
        winner_valid_q <= 1'b0;
        winner_id_q    <= 3'd0;
        move_ready_q   <= 1'b1;
        state_q        <= S_PLAY;
      end else begin
        if (init_i) err_q <= 1'b1;
        case (state_q)
          S_IDLE: state_q <= S_IDLE;
          S_PLAY: begin
            if (move_valid_i && move_ready_q) begin
              if (!player_ok_d) begin
                err_q <= 1'b1;
              end else if (move_steps_i == {STEP_W{1'b0}}) begin
                move_done_q <= 1'b1;
              end else begin
                mover_q      <= IDX_W'(move_player_i);
                remaining_q  <= move_steps_i;
                move_ready_q <= 1'b0;
                state_q      <= S_STEP;
              end
            end
          end
          S_STEP: begin
            pos_q[mover_q]  <= adv_pos_d;
            laps_q[mover_q] <= laps_adv_d;
            remaining_q     <= remaining_q - STEP_W'(1);
            if (remaining_q == STEP_W'(1)) state_q <= occupied_d ? S_SKIP : S_DONE;
          end
          S_SKIP: begin
            pos_q[mover_q]  <= adv_pos_d;
            laps_q[mover_q] <= laps_adv_d;
            if (!occupied_d) state_q <= S_DONE;
          end
          S_DONE: begin
            move_done_q <= 1'b1;
            if (laps_q[mover_q] >= LAP_W'(WIN_LAPS)) begin
              winner_valid_q <= 1'b1;
              winner_id_q    <= 3'(mover_q);
              state_q        <= S_WON;
            end else begin
              move_ready_q <= 1'b1;
              state_q      <= S_PLAY;
            end
          end
          S_WON: state_q <= S_WON;
          default: begin
            move_ready_q <= 1'b0;
            state_q      <= S_IDLE;
          end
        endcase
      end
    end
  end

  for (genvar g = 0; g < MAX_PLAYERS; g++) begin : g_pack
    assign pos_o[g*POS_W +: POS_W]  = pos_q[g];
    assign laps_o[g*LAP_W +: LAP_W] = laps_q[g];
  end

  assign active_o       = active_q;
  assign move_ready_o   = move_ready_q;
  assign move_done_o    = move_done_q;
  assign err_o          = err_q;
  assign winner_valid_o = winner_valid_q;
  assign winner_id_o    = winner_id_q;

endmodule

// File: tb/tb_chick_track_ctrl.sv
// Scoreboard bench for chick_track_ctrl: stimulus queues expected move_done/err events,
// a negedge monitor pops and compares them; directed vectors with hand-computed positions.
module tb_chick_track_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        init_i;
  logic [3:0]  num_players_i;
  logic        move_valid_i;
  logic        move_ready_o;
  logic [2:0]  move_player_i;
  logic [2:0]  move_steps_i;
  logic [19:0] pos_o;
  logic [7:0]  laps_o;
  logic [3:0]  active_o;
  logic        move_done_o;
  logic        err_o;
  logic        winner_valid_o;
  logic [2:0]  winner_id_o;

  chick_track_ctrl dut (
    .clk_i(clk), .rst_i(rst), .init_i(init_i), .num_players_i(num_players_i),
    .move_valid_i(move_valid_i), .move_ready_o(move_ready_o),
    .move_player_i(move_player_i), .move_steps_i(move_steps_i),
    .pos_o(pos_o), .laps_o(laps_o), .active_o(active_o),
    .move_done_o(move_done_o), .err_o(err_o),
    .winner_valid_o(winner_valid_o), .winner_id_o(winner_id_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_err;
    logic [19:0] pos;
    logic [7:0]  laps;
    logic        wv;
    logic [2:0]  wid;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic logic [19:0] p4(input int a3, input int a2, input int a1, input int a0);
    return {5'(a3), 5'(a2), 5'(a1), 5'(a0)};
  endfunction

  task automatic push(input bit is_err, input logic [19:0] p, input logic [7:0] l,
                      input logic wv, input logic [2:0] wid);
    exp_t e;
    e.is_err = is_err; e.pos = p; e.laps = l; e.wv = wv; e.wid = wid;
    exp_q.push_back(e);
  endtask

  // Monitor: every move_done or err pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!rst && (move_done_o || err_o)) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_event", {30'd0, move_done_o, err_o}, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("evt_err",  32'(err_o),          32'(mon_e.is_err));
        chk("evt_done", 32'(move_done_o),    32'(!mon_e.is_err));
        chk("evt_pos",  32'(pos_o),          32'(mon_e.pos));
        chk("evt_laps", 32'(laps_o),         32'(mon_e.laps));
        chk("evt_wv",   32'(winner_valid_o), 32'(mon_e.wv));
        chk("evt_wid",  32'(winner_id_o),    32'(mon_e.wid));
      end
    end
  end

  task automatic do_init(input logic [3:0] n);
    @(negedge clk);
    init_i = 1'b1; num_players_i = n;
    @(negedge clk);
    init_i = 1'b0;
  endtask

  task automatic chk_game(input string nm, input logic [19:0] p, input logic [3:0] act);
    chk({nm, "_pos"},    32'(pos_o),        32'(p));
    chk({nm, "_active"}, 32'(active_o),     32'(act));
    chk({nm, "_laps"},   32'(laps_o),       32'd0);
    chk({nm, "_ready"},  32'(move_ready_o), 32'd1);
  endtask

  // lat = clock edges from acceptance to the edge that raises move_done (steps + skips + 1).
  task automatic do_move(input logic [2:0] pl, input logic [2:0] st, input int from, input int lat,
                         input bit poke, input logic [19:0] ep, input logic [7:0] el,
                         input logic ewv, input logic [2:0] ewid);
    bit seen = 1'b0;
    push(1'b0, ep, el, ewv, ewid);
    @(negedge clk);
    chk("ready_before_move", 32'(move_ready_o), 32'd1);
    move_valid_i = 1'b1; move_player_i = pl; move_steps_i = st;
    for (int k = 1; k <= 64 && !seen; k++) begin
      @(negedge clk);
      if (k == 1) move_valid_i = poke;
      if (k == 3) move_valid_i = 1'b0;
      if (move_done_o) begin
        seen = 1'b1;
        chk("move_latency", 32'(k - 1), 32'(lat));
      end else begin
        chk("busy_not_ready", 32'(move_ready_o), 32'd0);
        chk("trace_tile", 32'(pos_o[int'(pl)*5 +: 5]), 32'((from + k - 1) % 24));
      end
    end
    if (!seen) chk("move_done_timeout", 32'd0, 32'd1);
    move_valid_i = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; init_i = 1'b0; num_players_i = 4'd0;
    move_valid_i = 1'b0; move_player_i = 3'd0; move_steps_i = 3'd0;
    repeat (3) @(negedge clk);
    chk("rst_pos",   32'(pos_o),          32'd0);
    chk("rst_laps",  32'(laps_o),         32'd0);
    chk("rst_active",32'(active_o),       32'd0);
    chk("rst_ready", 32'(move_ready_o),   32'd0);
    chk("rst_done",  32'(move_done_o),    32'd0);
    chk("rst_err",   32'(err_o),          32'd0);
    chk("rst_wv",    32'(winner_valid_o), 32'd0);
    chk("rst_wid",   32'(winner_id_o),    32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_ready", 32'(move_ready_o), 32'd0);

    // Start tiles
    do_init(4'd4);
    chk_game("init4", p4(18, 12, 6, 0), 4'b1111);
    do_init(4'd3);
    chk_game("init3", p4(0, 16, 8, 0), 4'b0111);

    // Rejected inits and out-of-range player leave the game untouched
    push(1'b1, p4(0, 16, 8, 0), 8'd0, 1'b0, 3'd0);
    do_init(4'd1);
    push(1'b1, p4(0, 16, 8, 0), 8'd0, 1'b0, 3'd0);
    do_init(4'd9);
    chk("bad_init_active", 32'(active_o), 32'b0111);
    push(1'b1, p4(0, 16, 8, 0), 8'd0, 1'b0, 3'd0);
    @(negedge clk);
    move_valid_i = 1'b1; move_player_i = 3'd3; move_steps_i = 3'd2;
    @(negedge clk);
    move_valid_i = 1'b0;
    @(negedge clk);
    chk("bad_player_pos",   32'(pos_o),        32'(p4(0, 16, 8, 0)));
    chk("bad_player_ready", 32'(move_ready_o), 32'd1);

    // Zero-step move: done next cycle, nothing moves
    do_move(3'd2, 3'd0, 16, 0, 1'b0, p4(0, 16, 8, 0), 8'd0, 1'b0, 3'd0);

    // Wrap and lap for p1 (start 12); first move also pokes move_valid while busy
    do_init(4'd2);
    chk_game("init2", p4(0, 0, 12, 0), 4'b0011);
    do_move(3'd1, 3'd7, 12, 8, 1'b1, p4(0, 0, 19, 0), 8'd0, 1'b0, 3'd0);
    do_move(3'd1, 3'd7, 19, 8, 1'b0, p4(0, 0, 2, 0),  8'd0, 1'b0, 3'd0);
    do_move(3'd1, 3'd7, 2,  8, 1'b0, p4(0, 0, 9, 0),  8'd0, 1'b0, 3'd0);
    do_move(3'd1, 3'd2, 9,  3, 1'b0, p4(0, 0, 11, 0), 8'd0, 1'b0, 3'd0);
    do_move(3'd1, 3'd1, 11, 2, 1'b0, p4(0, 0, 12, 0), 8'b0000_0100, 1'b0, 3'd0);

    // Collision skip: single skip, wrap without lap, double skip
    do_init(4'd4);
    do_move(3'd0, 3'd6, 0,  8, 1'b0, p4(18, 12, 6, 7), 8'd0, 1'b0, 3'd0);
    do_move(3'd3, 3'd7, 18, 8, 1'b0, p4(1, 12, 6, 7),  8'd0, 1'b0, 3'd0);
    do_move(3'd3, 3'd5, 1,  8, 1'b0, p4(8, 12, 6, 7),  8'd0, 1'b0, 3'd0);

    // Win: p0 laps twice
    do_init(4'd2);
    do_move(3'd0, 3'd7, 0,  8, 1'b0, p4(0, 0, 12, 7),  8'd0, 1'b0, 3'd0);
    do_move(3'd0, 3'd7, 7,  8, 1'b0, p4(0, 0, 12, 14), 8'd0, 1'b0, 3'd0);
    do_move(3'd0, 3'd7, 14, 8, 1'b0, p4(0, 0, 12, 21), 8'd0, 1'b0, 3'd0);
    do_move(3'd0, 3'd7, 21, 8, 1'b0, p4(0, 0, 12, 4),  8'd1, 1'b0, 3'd0);
    do_move(3'd0, 3'd7, 4,  8, 1'b0, p4(0, 0, 12, 11), 8'd1, 1'b0, 3'd0);
    do_move(3'd0, 3'd7, 11, 8, 1'b0, p4(0, 0, 12, 18), 8'd1, 1'b0, 3'd0);
    do_move(3'd0, 3'd7, 18, 8, 1'b0, p4(0, 0, 12, 1),  8'd2, 1'b1, 3'd0);
    @(negedge clk);
    chk("won_ready", 32'(move_ready_o), 32'd0);
    move_valid_i = 1'b1; move_player_i = 3'd1; move_steps_i = 3'd1;
    repeat (4) @(negedge clk);
    move_valid_i = 1'b0;
    chk("won_pos_frozen", 32'(pos_o),          32'(p4(0, 0, 12, 1)));
    chk("won_wv_held",    32'(winner_valid_o), 32'd1);
    do_init(4'd2);
    chk("reinit_wv", 32'(winner_valid_o), 32'd0);
    chk_game("reinit", p4(0, 0, 12, 0), 4'b0011);

    // Async reset in the middle of a move
    do_init(4'd4);
    @(negedge clk);
    move_valid_i = 1'b1; move_player_i = 3'd0; move_steps_i = 3'd5;
    @(negedge clk);
    move_valid_i = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_pos",    32'(pos_o),          32'd0);
    chk("arst_active", 32'(active_o),       32'd0);
    chk("arst_ready",  32'(move_ready_o),   32'd0);
    chk("arst_wv",     32'(winner_valid_o), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("arst_idle_ready", 32'(move_ready_o), 32'd0);
    chk("arst_idle_pos",   32'(pos_o),        32'd0);

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
